varre_pontos: RTL and testbench
===============================

# varre_pontos

Raster scanner that drives the point-in-triangle checker (`verPonto`) from the initiator side. It sweeps every pixel coordinate of an `H_RES`×`V_RES` frame in row-major order and presents each coordinate on `pt_x`/`pt_y`. It waits for the checker's `pt_pronto`, captures `pt_cor`, and emits one pixel beat per coordinate on a valid/ready stream toward the frame writer.

## Interface
- Parameters:
- `H_RES`, default 800: pixels per line; range 1..2047.
- `V_RES`, default 600: lines per frame; range 1..2047.
- `TIMEOUT`, default 64: WAIT-state watchdog limit in cycles. Used only with `VARRE_TIMEOUT_EN`.
- Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a frame; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until DONE.
- `done` out 1: one-cycle pulse after the last pixel handshake.
- `pt_x` out 11: coordinate to the checker; registered.
- `pt_y` out 11: coordinate to the checker; registered.
- `pt_pronto` in 1: checker ready; result valid.
- `pt_cor` in 1: checker result (1 = inside some triangle).
- `pix_valid` out 1: pixel beat valid.
- `pix_ready` in 1: downstream accepts the beat.
- `pix_x` out 11: coordinate of the beat.
- `pix_y` out 11: coordinate of the beat.
- `pix_cor` out 1: captured colour.
- `frame_end` out 1: high with `pix_valid` on the last beat only.
- `err` out 1: sticky watchdog flag. Exists only with `VARRE_TIMEOUT_EN`.

## Operation
- States: IDLE, SETTLE, WAIT, EMIT, DONE.
- IDLE: `busy`=0.
  - `start`=1 → load x=0, y=0 into `pt_x`/`pt_y`; go to SETTLE.
- SETTLE: exactly one cycle; `pt_pronto` is ignored. This covers the checker clearing `pronto` when its coordinates change. Then go to WAIT.
- WAIT: hold `pt_x`/`pt_y`.
  - On `pt_pronto`=1: register `pix_x`=x, `pix_y`=y, `pix_cor`=`pt_cor`; set `pix_valid`=1; go to EMIT.
- EMIT: hold `pix_*` stable while `pix_valid`=1 and `pix_ready`=0.
  - On `pix_valid`&`pix_ready`: drop `pix_valid` (unless the next beat is produced in the same cycle; it is not, since SETTLE intervenes).
  - If x=H_RES-1 and y=V_RES-1: go to DONE.
  - Else if x=H_RES-1: x←0, y←y+1.
  - Else: x←x+1.
  - After advancing, go to SETTLE.
- DONE: `done`=1 for one cycle, `busy`=0; go to IDLE.
- `frame_end` = `pix_valid` & (x=H_RES-1) & (y=V_RES-1).
- Counters are 11-bit unsigned. Wrap compares use `H_RES-1`/`V_RES-1` exactly; no overflow is possible in the legal parameter range.
- `start` while not IDLE is ignored. `start` held high in DONE is not seen until IDLE, so a back-to-back frame starts one cycle after `done`.
- H_RES=V_RES=1: a single beat with `frame_end`=1, then DONE.
- Reset (any state, including mid-frame): all outputs and counters go to 0, state goes to IDLE. The partial frame is abandoned and no `done` is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `pt_x`=0, `pt_y`=0, `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_cor`=0, `frame_end`=0, `err`=0.
- `start` at edge N → SETTLE at N+1, `busy`=1 from N+1.
- Per pixel, minimum 3 cycles: SETTLE 1, WAIT ≥1, EMIT ≥1.
- Frame minimum = 3·H_RES·V_RES + 2 cycles (IDLE→SETTLE, DONE).
- `pix_valid` rises the cycle after `pt_pronto` is sampled high in WAIT.
- `done` rises the cycle after the final handshake.

## Configuration
- `VARRE_TIMEOUT_EN` defined:
  - A counter runs in WAIT. If `pt_pronto` stays 0 for `TIMEOUT` consecutive cycles, emit the beat with `pix_cor`=0 and set `err`=1.
  - `err` is sticky until reset or the next accepted `start`.
- Undefined: no counter, no `err` port; WAIT waits indefinitely.

## Structure
- Package `varre_pkg`:
  - `COORD_W`=11.
  - `typedef enum` for the state, with the five states above.
  - coordinate typedef `coord_t` [COORD_W-1:0].
- Sub-module `varre_contador`: x/y raster counter with `load`, `inc`, outputs `x`, `y`, `last` (H_RES/V_RES parameters). The FSM lives in `varre_pontos`.

## Test plan
- H_RES=4, V_RES=3, checker model with `pt_pronto` 2 cycles after SETTLE, `pix_ready`=1 → 12 beats in order (0,0)…(3,2); `frame_end` only on (3,2); `done` one cycle after the last beat.
- Checker returns `pt_cor`=1 when x≥2 → `pix_cor` sequence 0,0,1,1 per line.
- `pix_ready` low for 5 cycles on beat (1,0) → `pix_x`/`pix_y`/`pix_cor` stable, `pt_x` not advanced, no beat lost or duplicated.
- `rst_n` low during beat (2,1) → all outputs 0 next sample; new `start` restarts at (0,0).
- `start` pulsed while `busy` → ignored, frame completes normally.
- `VARRE_TIMEOUT_EN`, TIMEOUT=8, `pt_pronto` stuck 0 → beat with `pix_cor`=0 after 8 WAIT cycles; `err`=1 and held.

Source files
------------

// File: rtl/varre_pkg.sv
// Shared types for the raster scanner: coordinate width, coordinate type, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package varre_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/varre_pontos_if.sv
// Bundle of the checker-side point bus and the pixel valid/ready stream.
// Latency: n/a (wires only).
// Backpressure: pix_ready from the frame writer stalls the scanner.
interface varre_pontos_if;
  import varre_pkg::*;

  // point-in-triangle checker side
  coord_t pt_x;
  coord_t pt_y;
  logic   pt_pronto;
  logic   pt_cor;

  // pixel stream toward the frame writer
  logic   pix_valid;
  logic   pix_ready;
  coord_t pix_x;
  coord_t pix_y;
  logic   pix_cor;
  logic   frame_end;

  // scanner side
  modport master (
    output pt_x, pt_y,
    input  pt_pronto, pt_cor,
    output pix_valid, pix_x, pix_y, pix_cor, frame_end,
    input  pix_ready
  );

  // checker + frame writer side
  modport slave (
    input  pt_x, pt_y,
    output pt_pronto, pt_cor,
    input  pix_valid, pix_x, pix_y, pix_cor, frame_end,
    output pix_ready
  );

endinterface

// File: rtl/varre_contador.sv
// Row-major x/y raster counter: load clears to (0,0), inc steps one pixel.
// Latency: outputs update on the edge where load/inc is sampled.
// Backpressure: none; the caller only pulses inc once per accepted pixel.
module varre_contador
  import varre_pkg::*;
#(
  parameter int H_RES = 800,
  parameter int V_RES = 600
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   inc,
  output coord_t x,
  output coord_t y,
  output logic   last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == coord_t'(H_RES - 1));
  assign y_end = (y == coord_t'(V_RES - 1));
  assign last  = x_end & y_end;

  // advance x, wrapping into the next line at the end of each row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/varre_pontos.sv
// Raster scanner: sweeps the frame, queries the checker per pixel, emits one beat per pixel.
// Latency: >=3 cycles per pixel (SETTLE, WAIT, EMIT) plus 2 per frame; done one cycle after last beat.
// Backpressure: pix_ready low holds the beat and coordinates; VARRE_TIMEOUT_EN adds a WAIT watchdog and err.
module varre_pontos
  import varre_pkg::*;
#(
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef VARRE_TIMEOUT_EN
  output logic err,
`endif
  varre_pontos_if.master bus
);

  state_t state;
  coord_t x;
  coord_t y;
  logic   last;
  logic   load;
  logic   inc;
  logic   pix_valid;
  coord_t pix_x;
  coord_t pix_y;
  logic   pix_cor;

`ifdef VARRE_TIMEOUT_EN
  logic [15:0] wcnt;
`endif

  // new frame on an accepted start; step only on a handshake that is not the last pixel
  assign load = (state == IDLE) & start;
  assign inc  = (state == EMIT) & bus.pix_ready & ~last;

  varre_contador #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .inc   (inc),
    .x     (x),
    .y     (y),
    .last  (last)
  );

  assign bus.pt_x      = x;
  assign bus.pt_y      = y;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_x     = pix_x;
  assign bus.pix_y     = pix_y;
  assign bus.pix_cor   = pix_cor;
  assign bus.frame_end = pix_valid & last;

  // scan sequencer with registered status and beat outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_cor   <= 1'b0;
`ifdef VARRE_TIMEOUT_EN
      err       <= 1'b0;
      wcnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            state <= SETTLE;
`ifdef VARRE_TIMEOUT_EN
            err   <= 1'b0;
`endif
          end
        end
        // one dead cycle so the checker can drop pronto for the new coordinate
        SETTLE: begin
          state <= WAIT;
`ifdef VARRE_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        WAIT: begin
          if (bus.pt_pronto) begin
            pix_x     <= x;
            pix_y     <= y;
            pix_cor   <= bus.pt_cor;
            pix_valid <= 1'b1;
            state     <= EMIT;
          end
`ifdef VARRE_TIMEOUT_EN
          else if (wcnt == 16'(TIMEOUT - 1)) begin
            // checker never answered: emit a background pixel and flag it
            pix_x     <= x;
            pix_y     <= y;
            pix_cor   <= 1'b0;
            pix_valid <= 1'b1;
            err       <= 1'b1;
            state     <= EMIT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        EMIT: begin
          if (bus.pix_ready) begin
            pix_valid <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_varre_pontos.sv
// Directed bench for the raster scanner on a 4x3 frame with a small checker model.
// Latency: checker answers two cycles after the scanner leaves its beat.
// Backpressure: pix_ready is driven per step, including a 5-cycle stall.
module tb_varre_pontos;
  import varre_pkg::*;

  localparam int H = 4;
  localparam int V = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
`ifdef VARRE_TIMEOUT_EN
  logic err;
`endif
  logic pronto_en;
  int   cnt;
  int   errors = 0;
  int   checks = 0;

  varre_pontos_if ifc ();

  varre_pontos #(
    .H_RES   (H),
    .V_RES   (V),
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
`ifdef VARRE_TIMEOUT_EN
    .err   (err),
`endif
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  // checker model: answers two cycles after the previous beat is gone
  always @(posedge clk) begin
    if (!busy || ifc.pix_valid) cnt <= 0;
    else if (cnt < 3) cnt <= cnt + 1;
  end
  assign ifc.pt_pronto = pronto_en && busy && !ifc.pix_valid && (cnt >= 2);
  assign ifc.pt_cor    = (ifc.pt_x >= 11'd2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pt_x"}, ifc.pt_x, 0);
    chk({tag, "_pt_y"}, ifc.pt_y, 0);
    chk({tag, "_pix_valid"}, ifc.pix_valid, 0);
    chk({tag, "_pix_x"}, ifc.pix_x, 0);
    chk({tag, "_pix_y"}, ifc.pix_y, 0);
    chk({tag, "_pix_cor"}, ifc.pix_cor, 0);
    chk({tag, "_frame_end"}, ifc.frame_end, 0);
`ifdef VARRE_TIMEOUT_EN
    chk({tag, "_err"}, err, 0);
`endif
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ifc.pix_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_beat_arrives"}, (n < 100), 1);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_pt_x", ifc.pt_x, 0);
    chk("start_pt_y", ifc.pt_y, 0);
  endtask

  // one beat: check fields, optionally stall, then confirm it is consumed once
  task automatic get_beat(input int ex, input int ey, input bit stall);
    if (stall) ifc.pix_ready = 1'b0;
    wait_valid("beat");
    chk("beat_pix_x", ifc.pix_x, ex);
    chk("beat_pix_y", ifc.pix_y, ey);
    chk("beat_pix_cor", ifc.pix_cor, (ex >= 2));
    chk("beat_frame_end", ifc.frame_end, (ex == H - 1 && ey == V - 1));
    if (stall) begin
      repeat (5) begin
        @(negedge clk);
        chk("stall_valid", ifc.pix_valid, 1);
        chk("stall_pix_x", ifc.pix_x, ex);
        chk("stall_pix_cor", ifc.pix_cor, (ex >= 2));
        chk("stall_pt_x", ifc.pt_x, ex);
      end
      ifc.pix_ready = 1'b1;
    end
    @(negedge clk);
    chk("beat_dropped", ifc.pix_valid, 0);
  endtask

  task automatic run_frame(input bit with_stall, input bit poke_start);
    do_start();
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        if (poke_start && xx == 0 && yy == 2) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        get_beat(xx, yy, with_stall && xx == 1 && yy == 0);
      end
    end
    chk("done_pulse", done, 1);
    chk("done_busy_low", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    pronto_en     = 1'b1;
    ifc.pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_busy", busy, 0);

    // full frame: ordering, colour pattern, stall on (1,0), start ignored while busy
    run_frame(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("no_extra_frame", busy, 0);

    // abandon a frame at beat (2,1) with reset
    do_start();
    for (int xx = 0; xx < H; xx++) get_beat(xx, 0, 1'b0);
    get_beat(0, 1, 1'b0);
    get_beat(1, 1, 1'b0);
    ifc.pix_ready = 1'b0;
    wait_valid("rst_beat");
    chk("rst_beat_x", ifc.pix_x, 2);
    chk("rst_beat_y", ifc.pix_y, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midreset");
    rst_n         = 1'b1;
    ifc.pix_ready = 1'b1;
    @(negedge clk);
    chk("midreset_no_done", done, 0);

    // restart after reset begins again at (0,0)
    run_frame(1'b0, 1'b0);

`ifdef VARRE_TIMEOUT_EN
    // checker silent: each beat comes out after 8 WAIT cycles with colour 0
    pronto_en = 1'b0;
    do_start();
    repeat (8) @(negedge clk);
    chk("to_not_yet", ifc.pix_valid, 0);
    chk("to_err_not_yet", err, 0);
    @(negedge clk);
    chk("to_valid", ifc.pix_valid, 1);
    chk("to_pix_x", ifc.pix_x, 0);
    chk("to_pix_cor", ifc.pix_cor, 0);
    chk("to_err_set", err, 1);
    @(negedge clk);
    wait_valid("to_b1");
    chk("to_b1_x", ifc.pix_x, 1);
    @(negedge clk);
    wait_valid("to_b2");
    chk("to_b2_x", ifc.pix_x, 2);
    chk("to_b2_cor", ifc.pix_cor, 0);
    chk("to_err_held", err, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("to_err_reset", err, 0);
    rst_n     = 1'b1;
    pronto_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
